// File: rtl/knight_light_pkg.sv
// Shared board types and stabilizer FSM states.
package knight_light_pkg;

  localparam int BOARD_SQUARES = 64;

  typedef logic [BOARD_SQUARES-1:0] board_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    COMMIT = 2'd2,
    REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/popcount64.sv
// Combinational population count of a 64-square board mask.
module popcount64
  import knight_light_pkg::*;
(
  input  board_t     din,
  output logic [6:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < BOARD_SQUARES; i++) begin
      count = count + 7'(din[i]);
    end
  end

endmodule

// File: rtl/board_stabilizer.sv
// Debounces scanned board frames and publishes lifted/placed masks.
// Popcount outputs are built only with BOARD_STABILIZER_POPCOUNT_EN.
module board_stabilizer
  import knight_light_pkg::*;
#(
  parameter int STABLE_FRAMES = 4,
  parameter int CNT_W         = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_valid,
  input  logic [63:0] layout_in,
  output logic [63:0] stable_layout,
  output logic [63:0] lifted,
  output logic [63:0] placed,
  output logic [6:0]  num_lifted,
  output logic [6:0]  num_placed,
  output logic        update_pending,
  input  logic        update_ack,
  output logic        overrun
);

  localparam logic [CNT_W-1:0] TARGET = CNT_W'(STABLE_FRAMES);

  state_t           state;
  board_t           candidate;
  logic [CNT_W-1:0] match_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      candidate <= '0;
      match_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_valid) begin
            if (layout_in == candidate) begin
              if (match_cnt < TARGET) match_cnt <= match_cnt + 1'b1;
            end else begin
              candidate <= layout_in;
              match_cnt <= CNT_W'(1);
            end
            state <= CHECK;
          end
        end
        CHECK: begin
          if (match_cnt == TARGET && candidate != stable_layout)
            state <= COMMIT;
          else
            state <= IDLE;
        end
        COMMIT: state <= REPORT;
        REPORT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_layout  <= '0;
      lifted         <= '0;
      placed         <= '0;
      update_pending <= 1'b0;
      overrun        <= 1'b0;
    end else if (state == COMMIT) begin
      lifted         <= stable_layout & ~candidate;
      placed         <= ~stable_layout & candidate;
      stable_layout  <= candidate;
      update_pending <= 1'b1;
      // An ack landing on the commit cycle consumes the old update.
      if (update_pending && !update_ack) overrun <= 1'b1;
    end else if (update_ack) begin
      update_pending <= 1'b0;
    end
  end

`ifdef BOARD_STABILIZER_POPCOUNT_EN
  logic [6:0] lifted_cnt;
  logic [6:0] placed_cnt;

  popcount64 u_pc_lifted (
    .din   (lifted),
    .count (lifted_cnt)
  );

  popcount64 u_pc_placed (
    .din   (placed),
    .count (placed_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_lifted <= '0;
      num_placed <= '0;
    end else if (state == REPORT) begin
      num_lifted <= lifted_cnt;
      num_placed <= placed_cnt;
    end
  end
`else
  assign num_lifted = '0;
  assign num_placed = '0;
`endif

endmodule
